// File: rtl/cpu_pkg.sv
// Shared definitions for the 9-bit CPU: sequencer states, default widths,
// the halt encoding and the opcode field values seen in IR[8:6].
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        EXEC    = 3'd2,
        MEMWAIT = 3'd3,
        HALT    = 3'd4
    } state_t;

    localparam int PCW_DEFAULT = 12;
    localparam int IW_DEFAULT  = 9;

    localparam logic [8:0] HALT_INSTR = 9'h1FF;

    localparam logic [2:0] OP_RXOR  = 3'b000;
    localparam logic [2:0] OP_SHIFT = 3'b001;
    localparam logic [2:0] OP_MEM   = 3'b010;
    localparam logic [2:0] OP_BEQ   = 3'b011;
    localparam logic [2:0] OP_HSET  = 3'b100;
    localparam logic [2:0] OP_BAND  = 3'b101;
    localparam logic [2:0] OP_BLT   = 3'b110;

endpackage

// File: rtl/instr_sequencer_cycle_counter.sv
// Saturating up-counter with synchronous clear and count enable; it sticks
// at all-ones rather than wrapping so long programs never report a short run.
module cycle_counter #(
    parameter int CNTW = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            clear,
    input  logic            enable,
    output logic [CNTW-1:0] count
);

    // Clear wins over enable; the all-ones check keeps the count from wrapping.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CNTW'(1);
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer: owns PC and IR, steps each instruction through
// FETCH/EXEC/MEMWAIT and gates the decoder's write enables to one cycle.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int PCW    = PCW_DEFAULT,
    parameter int IW     = IW_DEFAULT,
    parameter int MEMLAT = 1,
    parameter int CNTW   = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [PCW-1:0]  StartAddr,
    input  logic [IW-1:0]   Instr,
    input  logic            RegWrite,
    input  logic            MemWrite,
    input  logic            MemtoReg,
    input  logic            Branch,
    input  logic            BranchTaken,
    input  logic [PCW-1:0]  Target,
    output logic [PCW-1:0]  PC,
    output logic [IW-1:0]   IR,
    output logic            RegWrEn,
    output logic            MemWrEn,
    output logic            Done,
    output logic [CNTW-1:0] CycleCount
);

    localparam logic [2:0] MEMLAT_INIT = 3'(MEMLAT);

    state_t     state;
    logic [2:0] waitCnt;
    logic       isHalt;
    logic       startAccept;
    logic       countEnable;
    logic       loadDone;
    logic       takeBranch;

    assign isHalt      = (IR == IW'(HALT_INSTR));
    assign startAccept = Start && ((state == IDLE) || (state == HALT));
    assign countEnable = (state == FETCH) || (state == EXEC) || (state == MEMWAIT);
    assign loadDone    = (state == MEMWAIT) && (waitCnt == 3'd0);
    assign takeBranch  = Branch && BranchTaken;

    // Enables come purely from state so an asynchronous reset kills any
    // in-flight write the moment it is asserted.
    always_comb begin
        RegWrEn = 1'b0;
        MemWrEn = 1'b0;
        if ((state == EXEC) && !isHalt && !MemtoReg) begin
            RegWrEn = RegWrite;
            MemWrEn = MemWrite;
        end else if (loadDone) begin
            RegWrEn = RegWrite;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            PC      <= '0;
            IR      <= '0;
            Done    <= 1'b0;
            waitCnt <= 3'd0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (Start) begin
                        PC    <= StartAddr;
                        Done  <= 1'b0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    IR    <= Instr;
                    state <= EXEC;
                end
                EXEC: begin
                    if (isHalt) begin
                        Done  <= 1'b1;
                        state <= HALT;
                    end else if (MemtoReg) begin
                        waitCnt <= MEMLAT_INIT;
                        state   <= MEMWAIT;
                    end else begin
                        PC    <= takeBranch ? Target : PC + PCW'(1);
                        state <= FETCH;
                    end
                end
                MEMWAIT: begin
                    if (waitCnt != 3'd0) begin
                        waitCnt <= waitCnt - 3'd1;
                    end else begin
                        PC    <= PC + PCW'(1);
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    cycle_counter #(
        .CNTW (CNTW)
    ) u_cycle_counter (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  (startAccept),
        .enable (countEnable),
        .count  (CycleCount)
    );

endmodule
